// File: rtl/bcd_to_bin_seq_if.sv
// bcd_to_bin_seq_if
// Start/busy/done handshake bundle for the sequential BCD-to-binary converter.
//   start   : master -> slave, request a conversion (sampled only when idle)
//   bcd_in  : master -> slave, packed BCD, most significant digit in top nibble
//   busy    : slave -> master, conversion in progress
//   done    : slave -> master, one-cycle result-valid pulse
//   bin_out : slave -> master, binary result, held until the next done
//   err     : slave -> master, an input digit was >9, held until the next done
`timescale 1ns/1ps
interface bcd_to_bin_seq_if #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
);
  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  busy;
  logic                  done;
  logic [BIN_W-1:0]      bin_out;
  logic                  err;

  modport master (
    output start, bcd_in,
    input  busy, done, bin_out, err
  );

  modport slave (
    input  start, bcd_in,
    output busy, done, bin_out, err
  );
endinterface

// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq
// Multi-digit BCD to binary converter (reverse double dabble), one bit per
// clock. Each step shifts {bcd_reg, bin_reg} right by one, then subtracts 3
// from every BCD digit that is 8 or more. BIN_W steps per conversion; an
// invalid input digit is reported after a single cycle.
//   clk : system clock, rising edge
//   rst : asynchronous, active-high reset
//   bus : handshake/data bundle (slave side)
//
// state | meaning
// IDLE  | waiting for start, outputs hold last result
// CONV  | shifting/correcting, counter counts BIN_W down to 0
// ERR   | invalid digit seen, report err with done on the next edge
`timescale 1ns/1ps
module bcd_to_bin_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic           clk,
  input  logic           rst,
  bcd_to_bin_seq_if.slave bus
);
  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {IDLE, CONV, ERR} state_t;

  state_t             state, state_nxt;
  logic [BCD_W-1:0]   bcd_reg, bcd_nxt;
  logic [BIN_W-1:0]   bin_reg, bin_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [BIN_W-1:0]   bin_out_q, bin_out_nxt;
  logic               err_q, err_nxt;
  logic               done_q, done_nxt;

  logic [BCD_W-1:0]   bcd_sh, bcd_adj;
  logic [BIN_W-1:0]   bin_sh;
  logic               in_bad;

  // One reverse-dabble step: shift, then pull digits >=8 back into BCD range.
  always_comb begin
    bcd_sh  = bcd_reg >> 1;
    bin_sh  = {bcd_reg[0], bin_reg[BIN_W-1:1]};
    bcd_adj = bcd_sh;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_sh[4*i +: 4] >= 4'd8)
        bcd_adj[4*i +: 4] = bcd_sh[4*i +: 4] - 4'd3;
    end
  end

  always_comb begin
    in_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.bcd_in[4*i +: 4] > 4'd9)
        in_bad = 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    bcd_nxt     = bcd_reg;
    bin_nxt     = bin_reg;
    cnt_nxt     = cnt;
    bin_out_nxt = bin_out_q;
    err_nxt     = err_q;
    done_nxt    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          bcd_nxt   = bus.bcd_in;
          bin_nxt   = '0;
          cnt_nxt   = CNT_W'(BIN_W);
          state_nxt = in_bad ? ERR : CONV;
        end
      end
      CONV: begin
        bcd_nxt = bcd_adj;
        bin_nxt = bin_sh;
        cnt_nxt = cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          bin_out_nxt = bin_sh;
          err_nxt     = 1'b0;
          done_nxt    = 1'b1;
          state_nxt   = IDLE;
        end
      end
      ERR: begin
        bin_out_nxt = '0;
        err_nxt     = 1'b1;
        done_nxt    = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bcd_reg   <= '0;
      bin_reg   <= '0;
      cnt       <= '0;
      bin_out_q <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      bcd_reg   <= bcd_nxt;
      bin_reg   <= bin_nxt;
      cnt       <= cnt_nxt;
      bin_out_q <= bin_out_nxt;
      err_q     <= err_nxt;
      done_q    <= done_nxt;
    end
  end

  assign bus.busy    = (state != IDLE);
  assign bus.done    = done_q;
  assign bus.bin_out = bin_out_q;
  assign bus.err     = err_q;
endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb_bcd_to_bin_seq
// Directed self-checking bench for bcd_to_bin_seq (DIGITS=4, BIN_W=14).
`timescale 1ns/1ps
module tb_bcd_to_bin_seq;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  bcd_to_bin_seq_if #(.DIGITS(4), .BIN_W(14)) bif ();

  bcd_to_bin_seq #(.DIGITS(4), .BIN_W(14)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Pulse start for one edge, wait (bounded) for done, check the result.
  task automatic run_conv(input logic [15:0] bcd, input int exp_bin,
                          input int exp_err, input int exp_lat, input string tag);
    int n;
    int nbusy;
    bif.start  = 1'b1;
    bif.bcd_in = bcd;
    step();
    bif.start  = 1'b0;
    bif.bcd_in = 16'hFFFF;
    n = 0;
    nbusy = 0;
    while (!bif.done && n < 40) begin
      if (bif.busy) nbusy++;
      step();
      n++;
    end
    chk({tag, "_latency"}, n, exp_lat);
    chk({tag, "_busy_cycles"}, nbusy, exp_lat);
    chk({tag, "_bin_out"}, int'(bif.bin_out), exp_bin);
    chk({tag, "_err"}, int'(bif.err), exp_err);
    chk({tag, "_busy_at_done"}, int'(bif.busy), 0);
    step();
    chk({tag, "_done_one_cycle"}, int'(bif.done), 0);
  endtask

  initial begin
    int n;
    int ndone;
    int first;
    int last;
    logic prev_done;

    rst = 1'b1;
    bif.start  = 1'b0;
    bif.bcd_in = '0;
    step();
    step();
    chk("reset_busy", int'(bif.busy), 0);
    chk("reset_done", int'(bif.done), 0);
    chk("reset_err", int'(bif.err), 0);
    chk("reset_bin_out", int'(bif.bin_out), 0);
    rst = 1'b0;
    step();

    run_conv(16'h0000, 0, 0, 14, "zero");
    run_conv(16'h9999, 9999, 0, 14, "max");
    run_conv(16'h1234, 1234, 0, 14, "v1234");
    run_conv(16'h0008, 8, 0, 14, "v8");
    run_conv(16'h12A4, 0, 1, 1, "bad_digit");
    run_conv(16'h0042, 42, 0, 14, "after_err");

    // Second start while busy must be ignored.
    bif.start  = 1'b1;
    bif.bcd_in = 16'h0500;
    step();
    bif.start = 1'b0;
    n = 0;
    ndone = 0;
    while (n < 25) begin
      if (n == 4) begin
        bif.start  = 1'b1;
        bif.bcd_in = 16'h0077;
      end else begin
        bif.start = 1'b0;
      end
      step();
      n++;
      if (bif.done) begin
        ndone++;
        if (ndone == 1) begin
          chk("ignore_latency", n, 14);
          chk("ignore_bin_out", int'(bif.bin_out), 500);
        end
      end
    end
    chk("ignore_done_count", ndone, 1);

    // Asynchronous reset mid-conversion.
    bif.start  = 1'b1;
    bif.bcd_in = 16'h0100;
    step();
    bif.start = 1'b0;
    repeat (6) step();
    chk("pre_rst_busy", int'(bif.busy), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_busy", int'(bif.busy), 0);
    chk("async_rst_done", int'(bif.done), 0);
    chk("async_rst_bin_out", int'(bif.bin_out), 0);
    chk("async_rst_err", int'(bif.err), 0);
    step();
    step();
    rst = 1'b0;
    ndone = 0;
    repeat (20) begin
      step();
      if (bif.done) ndone++;
    end
    chk("rst_no_done", ndone, 0);
    run_conv(16'h0003, 3, 0, 14, "after_rst");

    // start held high: back-to-back conversions every 15 cycles.
    bif.start  = 1'b1;
    bif.bcd_in = 16'h0010;
    step();
    n = 0;
    ndone = 0;
    first = -1;
    last = -1;
    prev_done = 1'b0;
    while (ndone < 3 && n < 80) begin
      step();
      n++;
      if (bif.done) begin
        ndone++;
        chk("hold_bin_out", int'(bif.bin_out), 10);
        chk("hold_done_not_consecutive", int'(prev_done), 0);
        if (last >= 0) chk("hold_interval", n - last, 15);
        else first = n;
        last = n;
      end
      prev_done = bif.done;
    end
    chk("hold_done_count", ndone, 3);
    chk("hold_first_latency", first, 14);
    bif.start = 1'b0;
    repeat (20) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bcd_to_bin_seq.md
Name: bcd_to_bin_seq

Overview:
- Multi-digit BCD to binary converter using reverse double dabble.
- Each cycle shifts the BCD/binary pair right by one bit, then subtracts 3 from every BCD digit that is 8 or more.
- Companion to the combinational binary-to-BCD block. Converts keypad or display-entry BCD values back to binary for arithmetic datapaths.
- Interface is a start/busy/done handshake with one conversion in flight.

Parameters:
- DIGITS, 4: number of BCD digits in bcd_in.
- BIN_W, 14: binary output width. Must be at least ceil(log2(10^DIGITS)); 14 covers 9999.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a conversion. Sampled only when busy=0.
- bcd_in  input  4*DIGITS  packed BCD, most significant digit in the top nibble. Captured on the accepting edge.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when a result (or error) is valid.
- bin_out  output  BIN_W  binary result. Holds until the next done.
- err  output  1  set with done when any input digit is >9. Holds until the next done.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy, done, err = 0; bin_out=0; internal registers cleared. An in-flight conversion is abandoned with no done pulse.
- States: IDLE, CONV, ERR.
- IDLE, start=1 at edge E0:
  - Latch bcd_in into the BCD shift register, clear the binary shift register, load step counter = BIN_W.
  - If any digit >9, go to ERR; otherwise go to CONV.
  - busy=1 from E0.
- CONV, one step per edge:
  - {bcd_reg, bin_reg} shifts right 1; the LSB of bcd_reg enters the MSB of bin_reg.
  - After the shift, each 4-bit digit of bcd_reg that is ≥8 has 3 subtracted (all digits in parallel, same cycle).
  - Counter decrements by 1.
- CONV, last step (counter 1 -> 0 at edge E_BIN_W):
  - bin_out <= shifted bin_reg value, err <= 0, done=1 for the following cycle.
  - busy=0, state=IDLE.
  - Latency: done is high in the cycle after edge E0+BIN_W, which is 14 cycles for the default.
- ERR, at edge E1: bin_out <= 0, err <= 1, done=1 for one cycle, busy=0, state=IDLE. Error latency is 1 cycle.
- done is a registered one-cycle pulse and is never high for two consecutive cycles.
- start while busy=1 is ignored. bcd_in changes while busy have no effect.
- start during the done cycle is accepted, because the state is already IDLE. This gives back-to-back conversions with a new busy from that edge; done drops on that edge as normal.
- Arithmetic: digits stay within 0..9 throughout a valid conversion. After BIN_W steps, bcd_reg is all zero.
- Values needing more than BIN_W bits are a parameter misuse; there is no runtime check.

Test Plan:
- Reset, then bcd_in=16'h0000 with start pulse -> done after 14 cycles, bin_out=0, err=0; busy high for exactly 14 cycles.
- bcd_in=16'h9999 -> bin_out=14'd9999 (0x270F), err=0. bcd_in=16'h1234 -> bin_out=0x04D2. bcd_in=16'h0008 -> 8.
- bcd_in=16'h12A4 -> done 1 cycle after start, err=1, bin_out=0. A following valid conversion of 16'h0042 -> err=0, bin_out=42.
- Start 16'h0500, re-pulse start with 16'h0077 at cycle 5 -> second start ignored, result 500, exactly one done pulse.
- Start 16'h0100, assert rst at cycle 7 -> all outputs 0 immediately (asynchronous), no done. After release, 16'h0003 -> bin_out=3.
- Hold start high continuously with bcd_in=16'h0010 -> done every 15 cycles, each result 10, done never high two cycles in a row.
